// File: rtl/prog_seq_det_pkg.sv
// prog_seq_det_pkg: shared types and helpers for the programmable serial
// pattern detector.
//   state_t  : detector FSM states (IDLE = unconfigured, RUN = detecting)
//   MASK_W   : width of the compare mask returned by mask(). MAX_LEN must not
//              exceed this value.
//   len_w()  : width of a length field able to hold 0..max_len
//   mask()   : constant mask with the low 'len' bits set
package prog_seq_det_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int unsigned MASK_W = 32;

  function automatic int unsigned len_w(input int unsigned max_len);
    return $clog2(max_len + 1);
  endfunction

  function automatic logic [MASK_W-1:0] mask(input int unsigned len);
    logic [MASK_W-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < MASK_W; i++) begin
      if (i < len) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/prog_seq_detector_history.sv
// seq_det_history: bit-history shift register with a saturating fill counter.
//   clock   in  rising-edge clock
//   reset   in  asynchronous active-high reset
//   clr     in  clear history and fill (wins over shift)
//   shift   in  shift bit_in into the LSB and bump fill (saturates at MAX_LEN)
//   bit_in  in  serial bit to shift in
//   history out current history, bit 0 = most recent bit
//   fill    out number of valid history bits, 0..MAX_LEN
module seq_det_history
  import prog_seq_det_pkg::*;
#(
  parameter int unsigned MAX_LEN = 8,
  parameter int unsigned FILL_W  = len_w(MAX_LEN)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               clr,
  input  logic               shift,
  input  logic               bit_in,
  output logic [MAX_LEN-1:0] history,
  output logic [FILL_W-1:0]  fill
);

  logic [MAX_LEN-1:0] hist_q, hist_d;
  logic [FILL_W-1:0]  fill_q, fill_d;

  always_comb begin
    hist_d = hist_q;
    fill_d = fill_q;
    if (clr) begin
      hist_d = '0;
      fill_d = '0;
    end else if (shift) begin
      hist_d = {hist_q[MAX_LEN-2:0], bit_in};
      if (fill_q != FILL_W'(MAX_LEN)) fill_d = fill_q + FILL_W'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hist_q <= '0;
      fill_q <= '0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
    end
  end

  assign history = hist_q;
  assign fill    = fill_q;

endmodule

// File: rtl/prog_seq_detector.sv
// prog_seq_detector: runtime-programmable serial bit-pattern detector.
//   clock        in   rising-edge clock
//   reset        in   asynchronous active-high reset
//   sequence_in  in   serial data bit
//   in_valid     in   sequence_in qualifier
//   load         in   latch pattern/pat_len/overlap_en and clear history
//   pattern      in   pattern, bit pat_len-1 is received first, bit 0 last
//   pat_len      in   pattern length, legal 1..MAX_LEN
//   overlap_en   in   1 = overlapping matches, 0 = restart after a match
//   detector_out out  registered one-cycle match pulse
//   cfg_err      out  last load carried an illegal pat_len
//   match_count  out  saturating match counter
// Build option: define PROG_SEQ_DET_COUNT_EN to build the match counter;
// otherwise match_count is tied to zero.
module prog_seq_detector
  import prog_seq_det_pkg::*;
#(
  parameter int unsigned MAX_LEN = 8,
  parameter int unsigned CNT_W   = 8
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       sequence_in,
  input  logic                       in_valid,
  input  logic                       load,
  input  logic [MAX_LEN-1:0]         pattern,
  input  logic [len_w(MAX_LEN)-1:0]  pat_len,
  input  logic                       overlap_en,
  output logic                       detector_out,
  output logic                       cfg_err,
  output logic [CNT_W-1:0]           match_count
);

  localparam int unsigned LEN_W = len_w(MAX_LEN);

  state_t             state_q, state_d;
  logic [MAX_LEN-1:0] pat_q, pat_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               ovl_q, ovl_d;
  logic               err_q, err_d;
  logic               det_q, det_d;

  logic               len_legal;
  logic               accept;
  logic               match;
  logic               hist_clr;
  logic [MAX_LEN-1:0] history;
  logic [MAX_LEN-1:0] new_hist;
  logic [LEN_W-1:0]   fill;
  logic [LEN_W-1:0]   new_fill;

  assign len_legal = (pat_len != '0) && (pat_len <= LEN_W'(MAX_LEN));

  // Configuration / FSM next state. Load always latches the config, legal or not.
  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    len_d   = len_q;
    ovl_d   = ovl_q;
    err_d   = err_q;
    if (load) begin
      pat_d   = pattern;
      len_d   = pat_len;
      ovl_d   = overlap_en;
      err_d   = !len_legal;
      state_d = len_legal ? RUN : IDLE;
    end
  end

  // The match is judged on the value the history will hold after this edge,
  // so the completing bit produces the pulse on the very edge it is sampled.
  always_comb begin
    accept   = (state_q == RUN) && in_valid && !load;
    new_hist = {history[MAX_LEN-2:0], sequence_in};
    new_fill = (fill == LEN_W'(MAX_LEN)) ? fill : fill + LEN_W'(1);
    match    = (new_fill >= len_q) &&
               (((MASK_W'(new_hist) ^ MASK_W'(pat_q)) & mask(32'(len_q))) == '0);
    det_d    = accept && match;
    // Non-overlap restarts by clearing fill; the dropped shift is harmless
    // because history is ignored while fill is zero.
    hist_clr = load || (det_d && !ovl_q);
  end

  // The oldest history bit shifts out and is never compared.
  logic unused_hist_msb;
  assign unused_hist_msb = &{1'b0, history[MAX_LEN-1]};

  seq_det_history #(
    .MAX_LEN (MAX_LEN),
    .FILL_W  (LEN_W)
  ) u_history (
    .clock   (clock),
    .reset   (reset),
    .clr     (hist_clr),
    .shift   (accept),
    .bit_in  (sequence_in),
    .history (history),
    .fill    (fill)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      pat_q   <= '0;
      len_q   <= '0;
      ovl_q   <= 1'b0;
      err_q   <= 1'b0;
      det_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      len_q   <= len_d;
      ovl_q   <= ovl_d;
      err_q   <= err_d;
      det_q   <= det_d;
    end
  end

  assign detector_out = det_q;
  assign cfg_err      = err_q;

`ifdef PROG_SEQ_DET_COUNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (det_d && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign match_count = cnt_q;
`else
  assign match_count = '0;
`endif

endmodule

// File: tb/tb_prog_seq_detector.sv
module tb_prog_seq_detector;

  localparam int unsigned MAX_LEN = 8;
  localparam int unsigned CNT_W   = 2;
  localparam int          CNT_MAX = (1 << CNT_W) - 1;

  logic             clock = 1'b0;
  logic             reset;
  logic             sequence_in;
  logic             in_valid;
  logic             load;
  logic [7:0]       pattern;
  logic [3:0]       pat_len;
  logic             overlap_en;
  logic             detector_out;
  logic             cfg_err;
  logic [CNT_W-1:0] match_count;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  prog_seq_detector #(
    .MAX_LEN (MAX_LEN),
    .CNT_W   (CNT_W)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .sequence_in  (sequence_in),
    .in_valid     (in_valid),
    .load         (load),
    .pattern      (pattern),
    .pat_len      (pat_len),
    .overlap_en   (overlap_en),
    .detector_out (detector_out),
    .cfg_err      (cfg_err),
    .match_count  (match_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a queue of the bits accepted since the last restart,
  // checked against the tail of the programmed pattern.
  bit         q[$];
  bit         m_run  = 1'b0;
  int         m_len  = 0;
  logic [7:0] m_pat  = '0;
  bit         m_ov   = 1'b0;
  logic       exp_det = 1'b0;
  logic       exp_err = 1'b0;
  int         exp_cnt = 0;

  function automatic bit tail_matches();
    int n;
    n = q.size();
    if (n < m_len) return 1'b0;
    for (int i = 0; i < m_len; i++)
      if (q[n - m_len + i] != m_pat[m_len - 1 - i]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int model_count();
`ifdef PROG_SEQ_DET_COUNT_EN
    return exp_cnt;
`else
    return 0;
`endif
  endfunction

  initial begin
    forever begin
      @(posedge clock or posedge reset);
      if (reset) begin
        q.delete();
        m_run = 0; m_len = 0; m_pat = '0; m_ov = 0;
        exp_det = 0; exp_err = 0; exp_cnt = 0;
      end else begin
        exp_det = 0;
        if (load) begin
          q.delete();
          m_pat   = pattern;
          m_len   = int'(pat_len);
          m_ov    = overlap_en;
          m_run   = (m_len >= 1) && (m_len <= MAX_LEN);
          exp_err = !m_run;
        end else if (m_run && in_valid) begin
          q.push_back(sequence_in);
          if (q.size() > MAX_LEN) void'(q.pop_front());
          if (tail_matches()) begin
            exp_det = 1;
            if (exp_cnt < CNT_MAX) exp_cnt++;
            if (!m_ov) q.delete();
          end
        end
      end
    end
  end

  // Every-cycle comparison of all outputs against the model.
  initial begin
    forever begin
      @(negedge clock);
      chk("cyc_det", 32'(detector_out), 32'(exp_det));
      chk("cyc_err", 32'(cfg_err), 32'(exp_err));
      chk("cyc_cnt", 32'(match_count), model_count());
    end
  end

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic send(input logic b);
    sequence_in = b;
    in_valid    = 1'b1;
    tick();
    in_valid    = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) tick();
  endtask

  task automatic do_load(input logic [7:0] p, input logic [3:0] l, input logic o);
    pattern    = p;
    pat_len    = l;
    overlap_en = o;
    load       = 1'b1;
    tick();
    load       = 1'b0;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
  endtask

  int cnt_lit [5] = '{1, 2, 3, 3, 3};

  initial begin
    reset = 1'b1; load = 1'b0; in_valid = 1'b0; sequence_in = 1'b0;
    pattern = '0; pat_len = '0; overlap_en = 1'b0;
    repeat (2) tick();
    chk("rst_det", 32'(detector_out), 0);
    chk("rst_err", 32'(cfg_err), 0);
    chk("rst_cnt", 32'(match_count), 0);
    reset = 1'b0;
    tick();

    // Overlapping 1101 on 1101101: pulses after bits 4 and 7.
    do_load(8'b0000_1101, 4'd4, 1'b1);
    send(1); send(1); send(0); send(1);
    chk("ov_bit4", 32'(detector_out), 1);
    chk("ov_model4", 32'(exp_det), 1);
    send(1);
    chk("ov_bit5", 32'(detector_out), 0);
    send(0); send(1);
    chk("ov_bit7", 32'(detector_out), 1);

    // Non-overlapping: only the first pulse.
    do_load(8'b0000_1101, 4'd4, 1'b0);
    send(1); send(1); send(0); send(1);
    chk("nov_bit4", 32'(detector_out), 1);
    send(1); send(0); send(1);
    chk("nov_bit7", 32'(detector_out), 0);
    chk("nov_model7", 32'(exp_det), 0);

    // Gaps in in_valid hold history.
    do_load(8'b0000_1101, 4'd4, 1'b1);
    send(1); send(1);
    idle(3);
    chk("gap_det", 32'(detector_out), 0);
    send(0); send(1);
    chk("gap_bit4", 32'(detector_out), 1);

    // Load with in_valid high drops the bit and clears history.
    do_load(8'b0000_1101, 4'd4, 1'b1);
    send(1); send(1); send(0);
    sequence_in = 1'b1; in_valid = 1'b1;
    do_load(8'b0000_1101, 4'd4, 1'b1);
    in_valid = 1'b0;
    chk("drop_det", 32'(detector_out), 0);
    send(1);
    chk("drop_next", 32'(detector_out), 0);
    send(1); send(0); send(1);
    chk("drop_full", 32'(detector_out), 1);

    // Pattern bits above pat_len are ignored.
    do_load(8'b1111_0101, 4'd3, 1'b1);
    send(1); send(0); send(1);
    chk("mask_101", 32'(detector_out), 1);
    send(0); send(1);
    chk("mask_ovl", 32'(detector_out), 1);

    // Illegal lengths.
    do_load(8'hFF, 4'd0, 1'b1);
    chk("len0_err", 32'(cfg_err), 1);
    repeat (9) send(1);
    chk("len0_det", 32'(detector_out), 0);
    do_load(8'hFF, 4'd9, 1'b1);
    chk("len9_err", 32'(cfg_err), 1);
    repeat (9) send(1);
    chk("len9_det", 32'(detector_out), 0);
    do_load(8'h01, 4'd1, 1'b1);
    chk("legal_err", 32'(cfg_err), 0);
    send(1);
    chk("legal_det", 32'(detector_out), 1);

    // Saturating counter with back-to-back pulses.
    pulse_reset();
    do_load(8'h01, 4'd1, 1'b1);
    for (int k = 0; k < 5; k++) begin
      send(1);
      chk("b2b_det", 32'(detector_out), 1);
`ifdef PROG_SEQ_DET_COUNT_EN
      chk("cnt_lit", 32'(match_count), cnt_lit[k]);
`else
      chk("cnt_tied", 32'(match_count), 0);
`endif
    end
    send(0);
    chk("b2b_zero", 32'(detector_out), 0);

    // Reset mid-stream.
    pulse_reset();
    do_load(8'b0000_1101, 4'd4, 1'b1);
    send(1); send(1); send(0);
    reset = 1'b1;
    #1;
    chk("mrst_det", 32'(detector_out), 0);
    chk("mrst_err", 32'(cfg_err), 0);
    chk("mrst_cnt", 32'(match_count), 0);
    tick();
    reset = 1'b0;
    send(1);
    chk("mrst_noload", 32'(detector_out), 0);
    do_load(8'b0000_1101, 4'd4, 1'b1);
    send(1); send(1); send(0); send(1);
    chk("mrst_reload", 32'(detector_out), 1);
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
